dram_arbiter: RTL and testbench

//  Shares the single-port DRAM (registered output, 1-cycle read latency) among NUM_CORES cores.

---
 rtl/dram_arbiter.sv | 149 ++++++++++++++
 tb/tb_dram_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter sharing one single-port DRAM between
// NUM_CORES cores. The DRAM has a registered output, so a read takes one
// extra cycle. Only one transaction is in flight at a time, and read data is
// broadcast to every core on ddin.
//
// Optional build macro: ARB_STATS_EN
//   Defined:   per-core saturating completion counters drive grant_cnt.
//   Undefined: no counters are built and grant_cnt reads 0.
//
// Ports:
//   CLK                   rising-edge clock (clkdiv output)
//   rst                   synchronous, active-high reset
//   mem_ctrl[4N]          per-core Mem_Ctrl: [0]=read, [1]=write, [3:2] unused
//   daddr[8N], ddout[8N]  per-core address and write data
//   acq[N]                per-core grant/complete; 0 means the core stalls
//   ddin[8]               registered read data, broadcast to all cores
//   dram_address/dram_data/dram_wren   outputs to the DRAM
//   dram_q[8]             DRAM read data
//   owner[2]              core currently or most recently served
//   busy                  FSM is outside IDLE
//   grant_cnt[8N]         per-core completed-transaction counters

// Per-core slice: request decode, stall handshake, optional stats counter.
module dram_arbiter_lane (
  input  logic       CLK,
  input  logic       rst,
  input  logic [3:0] mem_ctrl,
  input  logic       done,
  output logic       req,
  output logic       wr,
  output logic       acq,
  output logic [7:0] cnt
);
  assign req = mem_ctrl[0] | mem_ctrl[1];
  assign wr  = mem_ctrl[1];                 // write wins when both bits are set
  assign acq = ~req | done;                 // idle cores run freely

`ifdef ARB_STATS_EN
  logic lane_unused;
  assign lane_unused = ^mem_ctrl[3:2];
  always_ff @(posedge CLK) begin
    if (rst)                      cnt <= '0;
    else if (done && cnt != 8'hFF) cnt <= cnt + 8'd1;
  end
`else
  logic lane_unused;
  assign lane_unused = ^{mem_ctrl[3:2], CLK, rst, done};
  assign cnt = '0;
`endif
endmodule

module dram_arbiter #(
  parameter int NUM_CORES = 4
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic [4*NUM_CORES-1:0] mem_ctrl,
  input  logic [8*NUM_CORES-1:0] daddr,
  input  logic [8*NUM_CORES-1:0] ddout,
  output logic [NUM_CORES-1:0]   acq,
  output logic [7:0]             ddin,
  output logic [7:0]             dram_address,
  output logic [7:0]             dram_data,
  output logic                   dram_wren,
  input  logic [7:0]             dram_q,
  output logic [1:0]             owner,
  output logic                   busy,
  output logic [8*NUM_CORES-1:0] grant_cnt
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t                        state;
  logic [1:0]                    last_owner;
  logic [1:0]                    win;
  logic                          is_wr;
  logic [NUM_CORES-1:0]          req, wr, done;
  logic [NUM_CORES-1:0][7:0]     cnt;

  genvar i;
  generate
    for (i = 0; i < NUM_CORES; i++) begin : g_lane
      assign done[i] = (state == DONE) && (owner == 2'(i));
      dram_arbiter_lane u_lane (
        .CLK      (CLK),
        .rst      (rst),
        .mem_ctrl (mem_ctrl[4*i +: 4]),
        .done     (done[i]),
        .req      (req[i]),
        .wr       (wr[i]),
        .acq      (acq[i]),
        .cnt      (cnt[i])
      );
    end
  endgenerate

  assign grant_cnt = cnt;

  // Round-robin pick: scan from farthest to nearest offset after last_owner
  // so the nearest requester overwrites the others.
  always_comb begin
    win = last_owner;
    for (int k = NUM_CORES; k >= 1; k--) begin
      logic [1:0] t;
      t = 2'((int'(last_owner) + k) % NUM_CORES);
      if (req[t]) win = t;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state        <= IDLE;
      last_owner   <= 2'(NUM_CORES - 1);
      owner        <= '0;
      is_wr        <= 1'b0;
      dram_address <= '0;
      dram_data    <= '0;
      dram_wren    <= 1'b0;
      ddin         <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          // Latch everything now so the requester may drop req mid-flight.
          owner        <= win;
          dram_address <= daddr[8*win +: 8];
          dram_data    <= ddout[8*win +: 8];
          dram_wren    <= wr[win];
          is_wr        <= wr[win];
          busy         <= 1'b1;
          state        <= ACCESS;
        end
        ACCESS: begin
          dram_wren <= 1'b0;
          state     <= is_wr ? DONE : WAIT;
        end
        WAIT: begin
          ddin  <= dram_q;                  // DRAM q valid one cycle after address
          state <= DONE;
        end
        DONE: begin
          last_owner <= owner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;
  localparam int N = 4;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             rst;
  logic [4*N-1:0]   mem_ctrl;
  logic [8*N-1:0]   daddr, ddout;
  logic [N-1:0]     acq;
  logic [7:0]       ddin, dram_address, dram_data, dram_q;
  logic             dram_wren;
  logic [1:0]       owner;
  logic             busy;
  logic [8*N-1:0]   grant_cnt;

  dram_arbiter #(.NUM_CORES(N)) dut (
    .CLK(CLK), .rst(rst), .mem_ctrl(mem_ctrl), .daddr(daddr), .ddout(ddout),
    .acq(acq), .ddin(ddin), .dram_address(dram_address), .dram_data(dram_data),
    .dram_wren(dram_wren), .dram_q(dram_q), .owner(owner), .busy(busy),
    .grant_cnt(grant_cnt)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // DRAM model: registered output, one-cycle read latency.
  logic [7:0] mem [256];
  initial for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  always @(posedge CLK) begin
    if (dram_wren) mem[dram_address] <= dram_data;
    dram_q <= mem[dram_address];
  end

  int n_checks = 0, n_fail = 0;
  logic [7:0] last_rd;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct { int core; int exp_lat; logic [7:0] exp_d; bit rd; } sb_t;
  sb_t sb[$];

  typedef struct { int core; logic [3:0] ctrl; logic [7:0] addr, data, exp_d; } vec_t;
  vec_t tbl [10];

  task automatic do_reset();
    @(negedge CLK);
    rst = 1'b1; mem_ctrl = '0;
    repeat (2) @(negedge CLK);
    rst = 1'b0; last_rd = 8'h00;
  endtask

  // One isolated transaction, started with the FSM in IDLE.
  task automatic txn(input int c, input logic [3:0] ctrl, input logic [7:0] a, d, exp_d);
    sb_t e, got;
    int start, n, saw_wr;
    bit bad_wr, w;
    w = ctrl[1];
    mem_ctrl[4*c +: 4] = ctrl; daddr[8*c +: 8] = a; ddout[8*c +: 8] = d;
    e.core = c; e.exp_lat = w ? 2 : 3; e.exp_d = exp_d; e.rd = !w;
    sb.push_back(e);
    start = cyc; n = 0; saw_wr = 0; bad_wr = 0;
    #1 chk("acq_stall", 32'(acq[c]), 0);
    do begin
      @(negedge CLK); n++;
      if (dram_wren) begin
        saw_wr++;
        if (dram_address !== a || dram_data !== d) bad_wr = 1;
      end
    end while (!acq[c] && n < 20);
    got = sb.pop_front();
    if (!acq[c]) begin
      n_checks++; n_fail++;
      $display("FAIL txn_timeout: core %0d got no acq, required acq within 20 cycles", c);
    end else begin
      chk("latency", 32'(cyc - start), 32'(got.exp_lat));
      chk("owner", 32'(owner), 32'(got.core));
      chk("wren_pulses", 32'(saw_wr), w ? 1 : 0);
      chk("wr_bus", 32'(bad_wr), 0);
      if (got.rd) begin
        chk("ddin", 32'(ddin), 32'(got.exp_d));
        last_rd = got.exp_d;
      end else chk("ddin_hold", 32'(ddin), 32'(last_rd));
    end
    mem_ctrl[4*c +: 4] = 4'h0;
    @(negedge CLK);
  endtask

  initial begin
    int ord[$];
    int prev, n, got_n, ex;
    bit first, d0, d2;
    logic [7:0] rr_exp [4];

    tbl[0] = '{0, 4'b0010, 8'h10, 8'hA5, 8'h00};
    tbl[1] = '{1, 4'b0001, 8'h10, 8'h00, 8'hA5};
    tbl[2] = '{2, 4'b0010, 8'h20, 8'h3C, 8'h00};
    tbl[3] = '{3, 4'b0001, 8'h20, 8'h00, 8'h3C};
    tbl[4] = '{1, 4'b0010, 8'h10, 8'h5A, 8'h00};
    tbl[5] = '{0, 4'b1101, 8'h10, 8'h00, 8'h5A};  // upper ctrl bits ignored
    tbl[6] = '{3, 4'b0010, 8'hFF, 8'h81, 8'h00};
    tbl[7] = '{2, 4'b0001, 8'hFF, 8'h00, 8'h81};
    tbl[8] = '{1, 4'b0011, 8'h40, 8'h77, 8'h00};  // both bits: write wins
    tbl[9] = '{0, 4'b0001, 8'h40, 8'h00, 8'h77};

    rst = 1'b1; mem_ctrl = '0; daddr = '0; ddout = '0; last_rd = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_addr", 32'(dram_address), 0);
    chk("rst_data", 32'(dram_data), 0);
    chk("rst_wren", 32'(dram_wren), 0);
    chk("rst_ddin", 32'(ddin), 0);
    chk("rst_cnt", grant_cnt, 0);
    chk("rst_acq", 32'(acq), 32'hF);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      txn(tbl[i].core, tbl[i].ctrl, tbl[i].addr, tbl[i].data, tbl[i].exp_d);

    // Stats: counters only move with ARB_STATS_EN.
    do_reset();
    for (int i = 0; i < 5; i++) txn(2, 4'b0010, 8'h80, 8'(i), 8'h00);
    chk("cnt_core2_5", 32'(grant_cnt[23:16]), STATS ? 5 : 0);
    chk("cnt_others", 32'({grant_cnt[31:24], grant_cnt[15:0]}), 0);
    for (int i = 0; i < 295; i++) txn(2, 4'b0010, 8'h80, 8'(i), 8'h00);
    chk("cnt_core2_sat", 32'(grant_cnt[23:16]), STATS ? 32'hFF : 0);

    // All cores reading continuously: strict rotation, 4 cycles apart.
    do_reset();
    rr_exp[0] = 8'h5A; rr_exp[1] = 8'h3C; rr_exp[2] = 8'h81; rr_exp[3] = 8'h77;
    daddr = {8'h40, 8'hFF, 8'h20, 8'h10};
    mem_ctrl = 16'h1111;
    for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) ord.push_back(i);
    prev = cyc; got_n = 0; n = 0; first = 1;
    while (got_n < 8 && n < 60) begin
      @(negedge CLK); n++;
      for (int i = 0; i < 4; i++) if (acq[i]) begin
        ex = (ord.size() > 0) ? ord.pop_front() : -1;
        chk("rr_order", 32'(i), 32'(ex));
        chk("rr_gap", 32'(cyc - prev), first ? 3 : 4);
        chk("rr_ddin", 32'(ddin), 32'(rr_exp[i]));
        prev = cyc; first = 0; got_n++;
      end
    end
    if (got_n < 8) begin
      n_checks++; n_fail++;
      $display("FAIL rr_timeout: got %0d completions, required 8", got_n);
    end
    mem_ctrl = '0; last_rd = 8'h77;
    @(negedge CLK);

    // Core3 read whose requester drops req during WAIT.
    mem_ctrl[15:12] = 4'b0001; daddr[31:24] = 8'h20;
    @(negedge CLK);                        // ACCESS
    @(negedge CLK);                        // WAIT
    mem_ctrl[15:12] = 4'h0;
    #1 chk("drop_acq", 32'(acq[3]), 1);
    chk("drop_busy", 32'(busy), 1);
    @(negedge CLK);                        // DONE
    chk("drop_owner", 32'(owner), 3);
    chk("drop_ddin", 32'(ddin), 32'h3C);
    @(negedge CLK);
    chk("drop_idle", 32'(busy), 0);
    last_rd = 8'h3C;
    txn(1, 4'b0001, 8'h10, 8'h00, 8'h5A);

    // Reset during ACCESS of a core2 write.
    do_reset();
    mem_ctrl[11:8] = 4'b0010; daddr[23:16] = 8'h33; ddout[23:16] = 8'hEE;
    @(negedge CLK);
    chk("rst4_wren_on", 32'(dram_wren), 1);
    chk("rst4_owner", 32'(owner), 2);
    rst = 1'b1;
    mem_ctrl[3:0] = 4'b0010; daddr[7:0] = 8'h34; ddout[7:0] = 8'h11;
    @(negedge CLK);
    chk("rst4_wren_off", 32'(dram_wren), 0);
    chk("rst4_busy", 32'(busy), 0);
    chk("rst4_acq2", 32'(acq[2]), 0);
    rst = 1'b0;
    d0 = 0; d2 = 0; n = 0;
    while (!d2 && n < 30) begin
      @(negedge CLK); n++;
      if (!d0 && acq[0]) begin
        d0 = 1; chk("rst4_first_core0", 32'(d2), 0);
        mem_ctrl[3:0] = 4'h0;
      end else if (acq[2]) begin
        d2 = 1; chk("rst4_core2_after", 32'(d0), 1);
      end
    end
    if (!d2) begin
      n_checks++; n_fail++;
      $display("FAIL rst4_timeout: core2 never completed, required completion");
    end
    mem_ctrl = '0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
